// File: rtl/dram_wbuf_arbiter.sv
// Shares one single-outstanding DRAM port between imem reads and dmem traffic.
// dmem writes are posted through a FIFO; a read that aliases a queued write waits for it.
module dram_wbuf_arbiter #(
  parameter int MEM_SCALE = 27,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ioe,
  input  logic [MEM_SCALE-1:0] iaddr,
  output logic [31:0]          irdata,
  output logic                 ivalid,
  input  logic                 doe,
  input  logic [MEM_SCALE-1:0] daddr,
  input  logic [31:0]          dwdata,
  input  logic [3:0]           dwe,
  output logic [31:0]          drdata,
  output logic                 dvalid,
  output logic                 dwritten,
  output logic                 dram_oe,
  output logic [MEM_SCALE-1:0] dram_addr,
  output logic [31:0]          dram_wdata,
  output logic [3:0]           dram_we,
  input  logic [31:0]          dram_rdata,
  input  logic                 dram_valid,
  input  logic                 dram_written
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_I, RD_D, WR} state_e;
  state_e state_q, state_d;

  logic                 ipend_q, ipend_d, dpend_q, dpend_d, wpend_q, wpend_d;
  logic [MEM_SCALE-1:0] iaddr_q, daddr_q, waddr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wbe_q;

  logic [MEM_SCALE-1:0] f_addr_q [DEPTH];
  logic [31:0]          f_data_q [DEPTH];
  logic [3:0]           f_be_q   [DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 ivalid_q, dvalid_q, dwritten_q;
  logic [31:0]          irdata_q, drdata_q;

  logic                 wr_in, wr_req, push, pop, ilaunch, dlaunch, iconf, dconf;
  logic [MEM_SCALE-1:0] push_addr;
  logic [31:0]          push_data;
  logic [3:0]           push_be;

  assign wr_in     = doe && (dwe != 4'b0);
  assign wr_req    = wr_in || wpend_q;
  // Room is judged on the count before the edge; a same-edge pop does not free a slot.
  assign push      = wr_req && (cnt_q < FULL);
  assign push_addr = wr_in ? daddr  : waddr_q;
  assign push_data = wr_in ? dwdata : wdata_q;
  assign push_be   = wr_in ? dwe    : wbe_q;
  assign pop       = (state_q == WR) && dram_written;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    iconf = 1'b0;
    dconf = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rptr_q;
      if (CW'(off) < cnt_q) begin
        if (f_addr_q[i][MEM_SCALE-1:2] == iaddr_q[MEM_SCALE-1:2]) iconf = 1'b1;
        if (f_addr_q[i][MEM_SCALE-1:2] == daddr_q[MEM_SCALE-1:2]) dconf = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dram_oe    = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    dram_we    = 4'b0;
    ilaunch    = 1'b0;
    dlaunch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q == FULL)            state_d = WR;
        else if (dpend_q && !dconf)   state_d = RD_D;
        else if (ipend_q && !iconf)   state_d = RD_I;
        else if (cnt_q != '0)         state_d = WR;
        case (state_d)
          WR: begin
            dram_oe    = 1'b1;
            dram_addr  = f_addr_q[rptr_q];
            dram_wdata = f_data_q[rptr_q];
            dram_we    = f_be_q[rptr_q];
          end
          RD_D: begin
            dram_oe   = 1'b1;
            dram_addr = daddr_q;
            dlaunch   = 1'b1;
          end
          RD_I: begin
            dram_oe   = 1'b1;
            dram_addr = iaddr_q;
            ilaunch   = 1'b1;
          end
          default: ;
        endcase
      end
      RD_I:    if (dram_valid)   state_d = IDLE;
      RD_D:    if (dram_valid)   state_d = IDLE;
      WR:      if (dram_written) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ipend_d = ioe || (ipend_q && !ilaunch);
  assign dpend_d = (doe && (dwe == 4'b0)) || (dpend_q && !dlaunch);
  assign wpend_d = wr_req && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ipend_q    <= 1'b0;
      dpend_q    <= 1'b0;
      wpend_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ivalid_q   <= 1'b0;
      dvalid_q   <= 1'b0;
      dwritten_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ipend_q    <= ipend_d;
      dpend_q    <= dpend_d;
      wpend_q    <= wpend_d;
      cnt_q      <= cnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      ivalid_q   <= (state_q == RD_I) && dram_valid;
      dvalid_q   <= (state_q == RD_D) && dram_valid;
      dwritten_q <= push;
    end
  end

  always_ff @(posedge clk) begin
    if (ioe) iaddr_q <= iaddr;
    if (doe) daddr_q <= daddr;
    if (wr_in) begin
      waddr_q <= daddr;
      wdata_q <= dwdata;
      wbe_q   <= dwe;
    end
    if (push) begin
      f_addr_q[wptr_q] <= push_addr;
      f_data_q[wptr_q] <= push_data;
      f_be_q[wptr_q]   <= push_be;
    end
    if ((state_q == RD_I) && dram_valid) irdata_q <= dram_rdata;
    if ((state_q == RD_D) && dram_valid) drdata_q <= dram_rdata;
  end

  assign irdata   = irdata_q;
  assign ivalid   = ivalid_q;
  assign drdata   = drdata_q;
  assign dvalid   = dvalid_q;
  assign dwritten = dwritten_q;
endmodule

// File: tb/tb_dram_wbuf_arbiter.sv
// Directed + random bench: a word-memory reference model and a DRAM responder drive and check the arbiter.
module tb_dram_wbuf_arbiter;
  logic        clk = 1'b0;
  logic        rst, ioe, doe, dram_valid, dram_written;
  logic [26:0] iaddr, daddr;
  logic [31:0] dwdata, dram_rdata;
  logic [3:0]  dwe;
  logic [31:0] irdata, drdata, dram_wdata;
  logic        ivalid, dvalid, dwritten, dram_oe;
  logic [26:0] dram_addr;
  logic [3:0]  dram_we;

  dram_wbuf_arbiter #(.MEM_SCALE(27), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ioe(ioe), .iaddr(iaddr), .irdata(irdata), .ivalid(ivalid),
    .doe(doe), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata), .dvalid(dvalid),
    .dwritten(dwritten), .dram_oe(dram_oe), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_we(dram_we), .dram_rdata(dram_rdata), .dram_valid(dram_valid),
    .dram_written(dram_written));

  always #5 clk = ~clk;

  typedef struct { logic [26:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  wr_t         exp_wq[$];
  logic [31:0] arch [int];
  logic [31:0] dmem [int];
  logic [26:0] cmd_addr[$];
  logic [3:0]  cmd_we[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int lat_cnt = 0, rd_lat = 0, wr_lat = 0, n_wdone = 0, wdone_at_dwr = 0, i_done = 0, d_done = 0;
  bit i_out, d_out, d_is_wr, busy, cmd_is_wr, hold_wr, stray;
  logic [31:0] i_exp, d_exp, rd_buf;
  logic [26:0] i_addr_out;

  function automatic logic [31:0] defval(int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [31:0] rd_arch(int w);
    return arch.exists(w) ? arch[w] : defval(w);
  endfunction
  function automatic logic [31:0] rd_dram(int w);
    return dmem.exists(w) ? dmem[w] : defval(w);
  endfunction
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: DRAM responder, then response monitors, all at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    ioe = 1'b0;
    doe = 1'b0;
    dram_valid = 1'b0;
    dram_written = 1'b0;
    if (!rst) begin
      if (busy) begin
        if (lat_cnt > 0) lat_cnt--;
        if (lat_cnt == 0 && !(cmd_is_wr && hold_wr)) begin
          if (cmd_is_wr) begin
            dram_written = 1'b1;
            n_wdone++;
          end else begin
            dram_valid = 1'b1;
            dram_rdata = rd_buf;
          end
          busy = 1'b0;
        end
      end
      if (dram_oe === 1'b1) begin
        int w;
        chk("dram_single_outstanding", 32'(busy), 0);
        cmd_addr.push_back(dram_addr);
        cmd_we.push_back(dram_we);
        w = int'(dram_addr >> 2);
        if (dram_we != 4'b0) begin
          if (exp_wq.size() == 0) chk("dram_unexpected_write", 32'(dram_addr), 32'hFFFFFFFF);
          else begin
            wr_t e;
            e = exp_wq.pop_front();
            chk("wr_order_addr", 32'(dram_addr), 32'(e.addr));
            chk("wr_order_data", dram_wdata, e.data);
            chk("wr_order_be", 32'(dram_we), 32'(e.be));
          end
          dmem[w] = merge(rd_dram(w), dram_wdata, dram_we);
          cmd_is_wr = 1'b1;
          lat_cnt = (wr_lat > 0) ? wr_lat : int'($urandom_range(1, 4));
        end else begin
          rd_buf = rd_dram(w);
          cmd_is_wr = 1'b0;
          lat_cnt = (rd_lat > 0) ? rd_lat : int'($urandom_range(1, 4));
        end
        busy = 1'b1;
      end
    end
    if (stray) dram_written = 1'b1;
    if (ivalid === 1'b1) begin
      chk("ivalid_once", 32'(i_out), 1);
      chk("irdata", irdata, i_exp);
      i_out = 1'b0;
      i_done++;
    end
    if (dvalid === 1'b1) begin
      chk("dvalid_once", 32'(d_out && !d_is_wr), 1);
      chk("drdata", drdata, d_exp);
      d_out = 1'b0;
      d_done++;
    end
    if (dwritten === 1'b1) begin
      chk("dwritten_once", 32'(d_out && d_is_wr), 1);
      d_out = 1'b0;
      wdone_at_dwr = n_wdone;
    end
  endtask

  task automatic issue_i(input logic [26:0] a);
    ioe = 1'b1;
    iaddr = a;
    i_out = 1'b1;
    i_addr_out = a;
    i_exp = rd_arch(int'(a >> 2));
  endtask

  task automatic issue_d(input logic [26:0] a, input bit wr, input logic [31:0] dat, input logic [3:0] be);
    int w;
    w = int'(a >> 2);
    doe = 1'b1;
    daddr = a;
    dwdata = dat;
    dwe = wr ? be : 4'h0;
    d_out = 1'b1;
    d_is_wr = wr;
    if (wr) begin
      arch[w] = merge(rd_arch(w), dat, be);
      exp_wq.push_back('{a, dat, be});
    end else d_exp = rd_arch(w);
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while ((i_out || d_out || busy || exp_wq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("settle_timeout", 32'(i_out || d_out || busy || exp_wq.size() != 0), 0);
    repeat (2) tick();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ivalid"}, 32'(ivalid), 0);
    chk({tag, "_dvalid"}, 32'(dvalid), 0);
    chk({tag, "_dwritten"}, 32'(dwritten), 0);
    chk({tag, "_dram_oe"}, 32'(dram_oe), 0);
    chk({tag, "_dram_we"}, 32'(dram_we), 0);
  endtask

  // Fetch with 1-cycle DRAM: dram_oe one cycle after ioe, ivalid three cycles after.
  task automatic timed_fetch(input string tag, input logic [26:0] a, input logic [31:0] v);
    arch[int'(a >> 2)] = v;
    dmem[int'(a >> 2)] = v;
    rd_lat = 1;
    issue_i(a);
    tick();
    chk({tag, "_oe"}, 32'(dram_oe), 1);
    chk({tag, "_addr"}, 32'(dram_addr), 32'(a));
    chk({tag, "_we"}, 32'(dram_we), 0);
    tick();
    chk({tag, "_ivalid_early"}, 32'(ivalid), 0);
    tick();
    chk({tag, "_ivalid"}, 32'(ivalid), 1);
    chk({tag, "_irdata"}, irdata, v);
    settle(20);
  endtask

  initial begin
    int base;
    rst = 1'b1; ioe = 1'b0; doe = 1'b0; iaddr = '0; daddr = '0; dwdata = '0; dwe = '0;
    dram_rdata = '0; dram_valid = 1'b0; dram_written = 1'b0;
    repeat (2) tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Uncontended fetch
    timed_fetch("t1", 27'h100, 32'hDEADBEEF);

    // Posted write then aliasing read, queued behind a slow fetch
    rd_lat = 6; wr_lat = 1;
    base = cmd_addr.size();
    issue_i(27'h1004);
    tick();
    issue_d(27'h200, 1'b1, 32'h11223344, 4'hF);
    tick();
    chk("t2_dwritten", 32'(dwritten), 1);
    issue_d(27'h200, 1'b0, '0, '0);
    tick();
    settle(60);
    chk("t2_ncmd", 32'(cmd_addr.size() - base), 3);
    chk("t2_first_write_addr", 32'(cmd_addr[base+1]), 32'h200);
    chk("t2_first_write_we", 32'(cmd_we[base+1]), 32'hF);
    chk("t2_then_read_addr", 32'(cmd_addr[base+2]), 32'h200);
    chk("t2_then_read_we", 32'(cmd_we[base+2]), 0);

    // Non-aliasing read overtakes queued writes
    base = cmd_addr.size();
    issue_i(27'h1008);
    tick();
    issue_d(27'h10, 1'b1, 32'hCAFE0010, 4'hF);
    tick();
    issue_d(27'h14, 1'b1, 32'hCAFE0014, 4'h3);
    tick();
    issue_d(27'h40, 1'b0, '0, '0);
    tick();
    settle(60);
    chk("t3_read_first_addr", 32'(cmd_addr[base+1]), 32'h40);
    chk("t3_read_first_we", 32'(cmd_we[base+1]), 0);
    chk("t3_wr0_addr", 32'(cmd_addr[base+2]), 32'h10);
    chk("t3_wr1_addr", 32'(cmd_addr[base+3]), 32'h14);

    // FIFO full: fifth write withheld until a slot drains
    rd_lat = 0; wr_lat = 1; hold_wr = 1'b1; n_wdone = 0;
    base = cmd_addr.size();
    for (int k = 0; k < 5; k++) begin
      issue_d(27'h300 + 27'(4 * k), 1'b1, 32'hA0000000 + 32'(k), 4'hF);
      tick();
      if (k < 4) chk("t4_dwritten_prompt", 32'(d_out), 0);
    end
    repeat (6) tick();
    chk("t4_fifth_withheld", 32'(d_out), 1);
    chk("t4_no_drain_while_held", 32'(n_wdone), 0);
    hold_wr = 1'b0;
    settle(80);
    chk("t4_fifth_after_pop", 32'(wdone_at_dwr >= 1), 1);
    for (int k = 0; k < 5; k++) begin
      chk("t4_order_addr", 32'(cmd_addr[base+k]), 32'h300 + 32'(4 * k));
      chk("t4_order_we", 32'(cmd_we[base+k]), 32'hF);
    end

    // Simultaneous imem and dmem reads: dmem goes first, each answered once
    rd_lat = 1;
    base = cmd_addr.size();
    begin
      int i0, d0;
      i0 = i_done; d0 = d_done;
      issue_i(27'h1010);
      issue_d(27'h208, 1'b0, '0, '0);
      tick();
      settle(30);
      repeat (4) tick();
      chk("t5_first_is_dmem", 32'(cmd_addr[base]), 32'h208);
      chk("t5_second_is_imem", 32'(cmd_addr[base+1]), 32'h1010);
      chk("t5_i_once", 32'(i_done - i0), 1);
      chk("t5_d_once", 32'(d_done - d0), 1);
    end

    // Reset while a write is held with three entries queued
    hold_wr = 1'b1; wr_lat = 1;
    for (int k = 0; k < 3; k++) begin
      issue_d(27'h400 + 27'(4 * k), 1'b1, 32'hB0000000 + 32'(k), 4'hF);
      tick();
    end
    repeat (2) tick();
    chk("t6_in_write", 32'(cmd_addr[cmd_addr.size()-1]), 32'h400);
    rst = 1'b1;
    tick();
    check_quiet("t6_reset");
    busy = 1'b0; hold_wr = 1'b0; i_out = 1'b0; d_out = 1'b0;
    exp_wq.delete();
    rst = 1'b0;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    base = cmd_addr.size();
    repeat (4) begin
      tick();
      check_quiet("t6_after_stray");
    end
    chk("t6_fifo_empty", 32'(cmd_addr.size() - base), 0);
    timed_fetch("t6_fetch", 27'h104, 32'h0BADF00D);

    // Random traffic against the word-memory model
    rd_lat = 0; wr_lat = 0;
    for (int it = 0; it < 800; it++) begin
      if (!d_out && $urandom_range(0, 2) == 0) begin
        logic [26:0] a;
        bit wr;
        a = 27'h200 + 27'(4 * $urandom_range(0, 7));
        wr = 1'($urandom_range(0, 1));
        if (wr && i_out && (i_addr_out >> 2) == (a >> 2)) wr = 1'b0;
        issue_d(a, wr, $urandom, 4'($urandom_range(1, 15)));
      end
      if (!i_out && $urandom_range(0, 2) == 0) begin
        if (d_out && d_is_wr) issue_i(27'h1000 + 27'(4 * $urandom_range(0, 15)));
        else                  issue_i(27'h200 + 27'(4 * $urandom_range(0, 7)));
      end
      tick();
    end
    settle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
